// File: rtl/uart_pkg.sv
// Shared UART types: TX FSM states, line-control field layout and the
// parity helper used by both the transmitter and the receive-side checker.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int OVERSAMPLE_DEF = 16;

  // Bit positions of the line-control fields inside LCR
  localparam int LCR_WLS_LSB = 0;
  localparam int LCR_WLS_MSB = 1;
  localparam int LCR_STB_BIT = 2;
  localparam int LCR_PEN_BIT = 3;
  localparam int LCR_EPS_BIT = 4;
  localparam int LCR_SP_BIT  = 5;
  localparam int LCR_BRK_BIT = 6;

  // Per-frame configuration; field order mirrors LCR[5:0] so a slice casts directly
  typedef struct packed {
    logic       sticky_parity;
    logic       eps;
    logic       pen;
    logic       stb;
    logic [1:0] wls;
  } frame_cfg_t;

  // Parity over the wls+5 transmitted bits only; bits above the word length are masked
  function automatic logic parity_bit(input logic [7:0] data,
                                      input logic [1:0] wls,
                                      input logic       eps,
                                      input logic       sticky);
    logic [7:0] mask;
    logic [7:0] masked;
    mask   = 8'hFF >> (2'd3 - wls);
    masked = data & mask;
    if (sticky)
      return ~eps;
    else if (eps)
      return ^masked;
    else
      return ~(^masked);
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmit serializer: pops bytes from a first-word-fall-through FIFO and
// sends start, 5..8 data bits LSB first, optional parity and 1/1.5/2 stop bits,
// one bit per OVERSAMPLE baud pulses.
//
// state  | meaning
// IDLE   | line high; pops the FIFO head and launches a frame when non-empty
// START  | start bit (low)
// DATA   | data bits, LSB first, wls+5 of them
// PARITY | parity bit computed at launch
// STOP   | stop bits (high), 16/24/32 ticks
module uart_tx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int CNT_W      = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic [1:0] wls,
  input  logic       stb,
  input  logic       pen,
  input  logic       eps,
  input  logic       sticky_parity,
  input  logic       set_break,
  input  logic       fifo_empty_i,
  input  logic [7:0] fifo_data_i,
  output logic       fifo_pop_o,
  output logic       tx_o,
  output logic       tx_busy_o
);

  localparam logic [CNT_W-1:0] TICK_ONE  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] TICK_HALF = CNT_W'(OVERSAMPLE + OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] TICK_TWO  = CNT_W'(2 * OVERSAMPLE - 1);

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] tick_q, tick_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  frame_cfg_t       cfg_q, cfg_d;
  logic             par_q, par_d;
  logic             tx_q;
  logic             line_d;
  logic [6:0]       lcr_bus;
  frame_cfg_t       cfg_in;
  logic             brk;
  logic [CNT_W-1:0] bit_last;
  logic             bit_end;
  logic [2:0]       data_last;

  // Pack the live LCR inputs at their register positions
  always_comb begin
    lcr_bus                          = '0;
    lcr_bus[LCR_WLS_MSB:LCR_WLS_LSB] = wls;
    lcr_bus[LCR_STB_BIT]             = stb;
    lcr_bus[LCR_PEN_BIT]             = pen;
    lcr_bus[LCR_EPS_BIT]             = eps;
    lcr_bus[LCR_SP_BIT]              = sticky_parity;
    lcr_bus[LCR_BRK_BIT]             = set_break;
  end

  assign cfg_in    = frame_cfg_t'(lcr_bus[LCR_SP_BIT:LCR_WLS_LSB]);
  assign brk       = lcr_bus[LCR_BRK_BIT];
  assign data_last = {1'b0, cfg_q.wls} + 3'd4;

  // Terminal tick count of the current bit; only STOP can be longer than one bit
  always_comb begin
    bit_last = TICK_ONE;
    if (state_q == STOP) begin
      if (!cfg_q.stb)
        bit_last = TICK_ONE;
      else if (cfg_q.wls == 2'b00)
        bit_last = TICK_HALF;
      else
        bit_last = TICK_TWO;
    end
  end

  assign bit_end = baud_pulse && (tick_q == bit_last);

  // Next-state, counters, shift register and unregistered line level
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    cfg_d      = cfg_q;
    par_d      = par_q;
    fifo_pop_o = 1'b0;
    line_d     = 1'b1;

    if (state_q != IDLE && baud_pulse) begin
      if (bit_end)
        tick_d = '0;
      else
        tick_d = tick_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        line_d = 1'b1;
        // rst gate keeps the pop strobe quiet while reset holds the FSM in IDLE
        if (rst && !fifo_empty_i) begin
          fifo_pop_o = 1'b1;
          shreg_d    = fifo_data_i;
          cfg_d      = cfg_in;
          par_d      = parity_bit(fifo_data_i, cfg_in.wls, cfg_in.eps, cfg_in.sticky_parity);
          tick_d     = '0;
          bit_d      = '0;
          state_d    = START;
        end
      end
      START: begin
        line_d = 1'b0;
        if (bit_end)
          state_d = DATA;
      end
      DATA: begin
        line_d = shreg_q[0];
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == data_last) begin
            bit_d   = '0;
            state_d = cfg_q.pen ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      PARITY: begin
        line_d = par_q;
        if (bit_end)
          state_d = STOP;
      end
      STOP: begin
        line_d = 1'b1;
        if (bit_end)
          state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; tx line is registered so it lags the state by one clk
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      cfg_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      cfg_q   <= cfg_d;
      par_q   <= par_d;
      tx_q    <= brk ? 1'b0 : line_d;
    end
  end

  assign tx_o      = tx_q;
  assign tx_busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with a small FWFT FIFO model and a baud divider.
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic       baud_pulse = 1'b0;
  logic [1:0] wls;
  logic       stb, pen, eps, sticky_parity, set_break;
  logic       fifo_empty_i;
  logic [7:0] fifo_data_i;
  logic       fifo_pop_o, tx_o, tx_busy_o;

  logic [7:0] mem [8];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         baud_div = 1;
  int         baud_ctr = 0;
  int         n_vec = 0;
  int         n_miss = 0;

  uart_tx dut (
    .clk           (clk),
    .rst           (rst),
    .baud_pulse    (baud_pulse),
    .wls           (wls),
    .stb           (stb),
    .pen           (pen),
    .eps           (eps),
    .sticky_parity (sticky_parity),
    .set_break     (set_break),
    .fifo_empty_i  (fifo_empty_i),
    .fifo_data_i   (fifo_data_i),
    .fifo_pop_o    (fifo_pop_o),
    .tx_o          (tx_o),
    .tx_busy_o     (tx_busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo_empty_i = (rd_ptr == wr_ptr);
  assign fifo_data_i  = mem[rd_ptr[2:0]];

  always @(posedge clk)
    if (rst && fifo_pop_o) rd_ptr <= rd_ptr + 1;

  always @(negedge clk) begin
    baud_ctr   = (baud_ctr + 1) % baud_div;
    baud_pulse = (baud_ctr == 0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[2:0]] = b;
    wr_ptr++;
  endtask

  task automatic set_lcr(input logic [1:0] w, input logic s, input logic p,
                         input logic e, input logic sp);
    wls = w; stb = s; pen = p; eps = e; sticky_parity = sp;
  endtask

  // Waits for busy, samples each line level mid-bit, checks busy length
  task automatic run_frame(input string tag, input int nlev, input logic [11:0] lev,
                           input int bl, input int total, input int poke, output int gap);
    int c;
    gap = 0;
    while (!tx_busy_o && gap < 3000) begin
      @(negedge clk);
      gap++;
    end
    if (!tx_busy_o) begin
      chk({tag, " start"}, {31'd0, tx_busy_o}, 32'd1);
      return;
    end
    c = 0;
    while (tx_busy_o && c < 5000) begin
      for (int i = 0; i < nlev; i++)
        if (c == 1 + i * bl + bl / 2)
          chk($sformatf("%s lev%0d", tag, i), {31'd0, tx_o}, {31'd0, lev[i]});
      if (c == poke) set_lcr(2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      c++;
    end
    chk({tag, " len"}, c, total);
  endtask

  initial begin
    int g, p0, c;
    rst = 1'b0;
    set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    set_break = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx_o}, 32'd1);
    chk("rst_busy", {31'd0, tx_busy_o}, 32'd0);
    chk("rst_pop", {31'd0, fifo_pop_o}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 0xA5
    p0 = rd_ptr;
    push(8'hA5);
    run_frame("8n1", 10, 12'h34A, 16, 160, -1, g);
    chk("8n1 pops", rd_ptr - p0, 1);

    // 7E1
    set_lcr(2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    push(8'h83);
    run_frame("7e1_83", 10, 12'h206, 16, 160, -1, g);
    push(8'h07);
    run_frame("7e1_07", 10, 12'h30E, 16, 160, -1, g);

    // 1.5 and 2 stop bits
    set_lcr(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    push(8'h1F);
    run_frame("5n15", 7, 12'h07E, 16, 120, -1, g);
    set_lcr(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    push(8'h2A);
    run_frame("6n2", 8, 12'h0D4, 16, 144, -1, g);

    // Back-to-back, stick parity (bit = ~eps = 1)
    set_lcr(2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
    p0 = rd_ptr;
    push(8'h11); push(8'h22); push(8'h33);
    run_frame("b2b_11", 11, 12'h622, 16, 176, -1, g);
    run_frame("b2b_22", 11, 12'h644, 16, 176, -1, g);
    chk("b2b gap2", g, 1);
    run_frame("b2b_33", 11, 12'h666, 16, 176, -1, g);
    chk("b2b gap3", g, 1);
    chk("b2b pops", rd_ptr - p0, 3);

    // Break mid-DATA
    set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    push(8'hFF);
    g = 0;
    while (!tx_busy_o && g < 100) begin @(negedge clk); g++; end
    chk("brk start", {31'd0, tx_busy_o}, 32'd1);
    c = 0;
    while (tx_busy_o && c < 5000) begin
      if (c == 30) chk("brk pre", {31'd0, tx_o}, 32'd1);
      if (c == 41) chk("brk on", {31'd0, tx_o}, 32'd0);
      if (c == 61) chk("brk off", {31'd0, tx_o}, 32'd1);
      if (c == 40) set_break = 1'b1;
      if (c == 60) set_break = 1'b0;
      @(negedge clk);
      c++;
    end
    chk("brk len", c, 160);

    // Reset mid-frame
    push(8'h55);
    g = 0;
    while (!tx_busy_o && g < 100) begin @(negedge clk); g++; end
    repeat (50) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mrst tx", {31'd0, tx_o}, 32'd1);
    chk("mrst busy", {31'd0, tx_busy_o}, 32'd0);
    chk("mrst pop", {31'd0, fifo_pop_o}, 32'd0);
    @(negedge clk);
    p0 = rd_ptr;
    push(8'h3C);
    @(negedge clk);
    chk("mrst pop held", {31'd0, fifo_pop_o}, 32'd0);
    @(negedge clk);
    chk("mrst no pop", rd_ptr - p0, 0);
    rst = 1'b1;
    run_frame("post_rst", 10, 12'h278, 16, 160, -1, g);

    // Baud every 4 clk, LCR change mid-frame ignored
    baud_div = 4;
    repeat (8) @(negedge clk);
    g = 0;
    do begin @(posedge clk); g++; end while (!baud_pulse && g < 20);
    @(negedge clk);
    push(8'hC3);
    run_frame("baud4", 10, 12'h386, 64, 639, 200, g);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Transmit serializer of the 16550A-compatible UART.
- Sits directly downstream of the register block: it consumes bytes from the TX FIFO that the register block fills via its TX push strobe.
- It takes the 16x baud pulse that the register block produces as baud_out, plus the line-control (LCR) fields.
- It drives the serial TX line with start, data, optional parity and stop bits, and reports busy status for LSR.TEMT.

Parameters:
- OVERSAMPLE, 16, baud_pulse ticks per serial bit.
- CNT_W, 5, tick counter width; must hold 2*OVERSAMPLE-1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- baud_pulse  input  1  one-clk pulse at 16x bit rate (from baud_out)
- wls  input  2  LCR[1:0] word length: 00=5, 01=6, 10=7, 11=8 bits
- stb  input  1  LCR[2] stop bits select
- pen  input  1  LCR[3] parity enable
- eps  input  1  LCR[4] even parity select
- sticky_parity  input  1  LCR[5] stick parity
- set_break  input  1  LCR[6] break control
- fifo_empty_i  input  1  TX FIFO empty (first-word-fall-through)
- fifo_data_i  input  8  TX FIFO head byte, valid when fifo_empty_i=0
- fifo_pop_o  output  1  one-clk pop strobe to TX FIFO
- tx_o  output  1  serial line out (idle high)
- tx_busy_o  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset values (rst=0, asynchronous): tx_o=1, fifo_pop_o=0, tx_busy_o=0, state=IDLE, counters=0. Reset mid-frame aborts the frame immediately; no partial stop bit is sent.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE, frame launch:
  - In any clk cycle in IDLE with fifo_empty_i=0: assert fifo_pop_o for exactly that cycle.
  - Latch fifo_data_i into the shift register and latch wls/stb/pen/eps/sticky_parity into a frame-config register.
  - Clear the tick counter and go to START.
  - No baud_pulse alignment is required at launch.
- Mid-frame LCR changes have no effect; they apply to the next frame.
- Bit timing: the tick counter increments only on baud_pulse. A bit ends on the baud_pulse that brings the count to OVERSAMPLE-1; the counter then clears and the FSM advances.
- START: tx_o=0 for 16 ticks, then DATA.
- DATA:
  - Shift out LSB first.
  - Send wls+5 bits; the bit index counts 0..wls+4.
  - After the last bit, go to PARITY if pen=1, else STOP.
- PARITY: the parity bit is computed over the transmitted bits only (upper bits masked):
  - sticky_parity=1: bit = ~eps.
  - sticky_parity=0, eps=1 (even): bit = XOR of data bits.
  - sticky_parity=0, eps=0 (odd): bit = XNOR of data bits.
- STOP: tx_o=1.
  - Length is 16 ticks if stb=0.
  - Length is 24 ticks if stb=1 and wls=00 (1.5 stop bits).
  - Length is 32 ticks otherwise.
  - At the end, go to IDLE; if fifo_empty_i=0 the pop happens in that same cycle, so frames run back-to-back with no idle gap beyond at most one clk.
- tx_o is registered: it changes one clk after a state or bit transition. fifo_pop_o is combinational from state==IDLE and !fifo_empty_i.
- Break: while set_break=1, tx_o is forced to 0 regardless of state. The FSM keeps running and popping. When set_break is released, tx_o resumes the current state's value on the next clk.
- tx_busy_o is 1 from the cycle after the pop through the last STOP tick. It stays low in IDLE even if the FIFO is non-empty, for the pop cycle only.
- baud_pulse held high continuously is legal: one tick per clk.

Decomposition:
- Shared package uart_pkg holds:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - localparam OVERSAMPLE_DEF=16;
  - LCR field bit positions, consistent with csr_t;
  - a parity function used by both uart_tx and the future uart_rx checker.
- No sub-module: the FSM, tick counter, bit counter and shift register are one block of about 200 lines.

Test Plan:
- 8N1: wls=11, pen=0, stb=0, push 0xA5, baud_pulse every clk → exactly one pop; tx_o = 0,1,0,1,0,0,1,0,1,1, each level held 16 clk; tx_busy_o high 160 clk.
- 7E1 parity: wls=10, pen=1, eps=1, byte 0x83 → 7 data bits 1,1,0,0,0,0,0, then parity bit 0 (even over 0x03); byte 0x07 → parity bit 1.
- 5-bit 1.5 stop: wls=00, stb=1, byte 0x1F → stop high for 24 ticks; with wls=01, stb=1 → 32 ticks.
- Back-to-back: three bytes queued, stick parity pen=1, sticky_parity=1, eps=0 → three pops, frames contiguous with ≤1 clk gap, parity bit 1 on each frame.
- Break and reset: set_break=1 mid-DATA → tx_o=0 within 1 clk and FSM still completes on time; assert rst mid-frame → tx_o=1 and tx_busy_o=0 asynchronously, no pop until rst releases.
- Baud gating: baud_pulse every 4 clk → each bit lasts 64 clk; an LCR change mid-frame does not alter the current frame.
